// File: rtl/pipe_pkg.sv
// Shared encodings for the execute/writeback stage.
// Shift/logic codes, opcode classes, sequencer states.
package pipe_pkg;

   localparam logic [1:0] SH_ADD   = 2'd0;
   localparam logic [1:0] SH_SHL   = 2'd1;
   localparam logic [1:0] SH_SHR   = 2'd2;
   localparam logic [1:0] SH_LOGIC = 2'd3;

   localparam logic [2:0] LG_ZERO = 3'd0;
   localparam logic [2:0] LG_INV  = 3'd1;
   localparam logic [2:0] LG_XOR  = 3'd2;
   localparam logic [2:0] LG_AND  = 3'd3;
   localparam logic [2:0] LG_PASS = 3'd4;
   localparam logic [2:0] LG_OR   = 3'd5;
   localparam logic [2:0] LG_ONES = 3'd6;

   typedef enum logic [1:0] {
      CL_NOP,
      CL_ALU,
      CL_CMP,
      CL_LDI
   } op_class_e;

   typedef enum logic {
      IDLE,
      IMM_WAIT
   } state_e;

   // Suppress wins: stage1 only raises it for LDI opcodes.
   function automatic op_class_e classify(
      input logic [7:0] op,
      input logic       sup
   );
      logic [3:0] hi;
      logic [5:0] top;
      hi  = op[7:4];
      top = op[7:2];
      if (sup)
         return CL_LDI;
      else if (hi inside {4'd1, 4'd2, 4'd9, 4'd10, 4'd11} ||
               top inside {6'd1, 6'd12, 6'd32, 6'd33, 6'd34})
         return CL_ALU;
      else if (hi == 4'd12)
         return CL_CMP;
      else
         return CL_NOP;
   endfunction

endpackage

// File: rtl/pipe_alu.sv
// Combinational ALU: operand transform, adder, shifter, logic unit.
// Produces the result value plus carry, zero and negative flags.
module pipe_alu
   import pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       shift,
   input  logic [2:0]       logic_op,
   input  logic             cin,
   output logic [WIDTH-1:0] value,
   output logic             cout,
   output logic             z,
   output logic             n
);

   logic [WIDTH-1:0] bop;
   logic [WIDTH-1:0] lres;
   logic [WIDTH:0]   sum;

   always_comb begin
      bop = b;
      case (logic_op)
         LG_ZERO: bop = '0;
         LG_INV:  bop = ~b;
         LG_ONES: bop = '1;
         default: bop = b;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};

   always_comb begin
      lres = '0;
      case (logic_op)
         LG_XOR:  lres = a ^ b;
         LG_AND:  lres = a & b;
         LG_OR:   lres = a | b;
         default: lres = '0;
      endcase
   end

   always_comb begin
      value = sum[WIDTH-1:0];
      cout  = sum[WIDTH];
      unique case (shift)
         SH_ADD: begin
            value = sum[WIDTH-1:0];
            cout  = sum[WIDTH];
         end
         SH_SHL: begin
            value = {a[WIDTH-2:0], 1'b0};
            cout  = a[WIDTH-1];
         end
         SH_SHR: begin
            value = {1'b0, a[WIDTH-1:1]};
            cout  = a[0];
         end
         SH_LOGIC: begin
            value = lres;
            cout  = 1'b0;
         end
      endcase
   end

   assign z = (value == '0);
   assign n = value[WIDTH-1];

endmodule

// File: rtl/pipe_stage2.sv
// Execute/writeback stage: register file, ALU writeback, flags,
// and the two-byte load-immediate sequence.
module pipe_stage2
   import pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             pipe_in,
   input  logic [1:0]             lhs,
   input  logic [1:0]             rhs,
   input  logic [1:0]             in_shift,
   input  logic [2:0]             in_logic,
   input  logic [1:0]             in_carry,
   input  logic                   in_fetch_suppress,
   output logic [WIDTH-1:0]       result,
   output logic                   wb_valid,
   output logic [1:0]             wb_reg,
   output logic                   flag_z,
   output logic                   flag_c,
   output logic                   flag_n,
   output logic                   imm_pending,
   output logic [NREGS*WIDTH-1:0] dbg_regs
);

   logic [WIDTH-1:0] regs [NREGS];
   state_e           state;
   op_class_e        cls;
   logic [WIDTH-1:0] value;
   logic             cout;
   logic             z;
   logic             n;
   logic             unused;

   assign unused = in_carry[1];
   assign cls    = classify(pipe_in, in_fetch_suppress);

   pipe_alu #(.WIDTH(WIDTH)) u_alu (
      .a        (regs[lhs]),
      .b        (regs[rhs]),
      .shift    (in_shift),
      .logic_op (in_logic),
      .cin      (in_carry[0]),
      .value    (value),
      .cout     (cout),
      .z        (z),
      .n        (n)
   );

   // wb_reg doubles as the pending LDI destination while in IMM_WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         state    <= IDLE;
         result   <= '0;
         wb_valid <= 1'b0;
         wb_reg   <= '0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
         flag_n   <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               unique case (cls)
                  CL_LDI: begin
                     state  <= IMM_WAIT;
                     wb_reg <= pipe_in[1:0];
                  end
                  CL_ALU: begin
                     regs[lhs] <= value;
                     result    <= value;
                     wb_valid  <= 1'b1;
                     wb_reg    <= lhs;
                     flag_z    <= z;
                     flag_c    <= cout;
                     flag_n    <= n;
                  end
                  CL_CMP: begin
                     flag_z <= z;
                     flag_c <= cout;
                     flag_n <= n;
                  end
                  CL_NOP: ;
               endcase
            end
            IMM_WAIT: begin
               regs[wb_reg] <= WIDTH'(pipe_in);
               result       <= WIDTH'(pipe_in);
               wb_valid     <= 1'b1;
               state        <= IDLE;
            end
         endcase
      end
   end

   assign imm_pending = (state == IMM_WAIT);

   always_comb begin
      dbg_regs = '0;
      for (int i = 0; i < NREGS; i++)
         dbg_regs[i*WIDTH +: WIDTH] = regs[i];
   end

endmodule
